// File: rtl/bus_arb_pkg.sv
// Shared types and default widths for the bus cycle arbiter.
// Imported by bus_cycle_arbiter and rr_pick.
package bus_arb_pkg;

    typedef enum logic [1:0] {IDLE, T1, T2, T3} bus_state_t;

    localparam int DEF_ADDR_WIDTH = 19;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first eligible requester after 'last'
// (wrapping modulo NUM_REQ) wins.
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IW      = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IW-1:0]      last,
    output logic [NUM_REQ-1:0] winner,
    output logic [IW-1:0]      winner_idx,
    output logic               any_eligible
);

    int   cand;
    logic found;

    always_comb begin
        winner     = '0;
        winner_idx = '0;
        found      = 1'b0;
        cand       = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(last) + k) % NUM_REQ;
            if (!found && eligible[IW'(cand)]) begin
                found              = 1'b1;
                winner[IW'(cand)]  = 1'b1;
                winner_idx         = IW'(cand);
            end
        end
    end

    assign any_eligible = |eligible;

endmodule

// File: rtl/bus_cycle_arbiter.sv
// Round-robin bus master running fixed T1/T2/T3 cycles on an 8088-style device.
// Optional bus locking is compiled in with `define BUS_ARB_LOCK_EN.
module bus_cycle_arbiter
    import bus_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_REQ    = DEF_NUM_REQ
) (
    input  logic                           CLK,
    input  logic                           RESET,
    input  logic [NUM_REQ-1:0]             REQ,
    input  logic [NUM_REQ-1:0]             REQ_WR,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_WDATA,
    input  logic [NUM_REQ-1:0]             REQ_LOCK,
    output logic [NUM_REQ-1:0]             GNT,
    output logic [NUM_REQ-1:0]             DONE,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic                           ALE,
    output logic                           CS,
    output logic                           RD,
    output logic                           WR,
    output logic [ADDR_WIDTH-1:0]          ADDRESS,
    inout  wire  [DATA_WIDTH-1:0]          DATA
);

    localparam int IW = idx_width(NUM_REQ);

    bus_state_t            state;
    logic [IW-1:0]         last;
    logic [IW-1:0]         owner;
    logic [IW-1:0]         pick_last;
    logic [IW-1:0]         pick_idx;
    logic [NUM_REQ-1:0]    eligible;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic                  pick_any;
    logic                  launch;
    logic                  wr_q;
    logic                  data_oe;
    logic [DATA_WIDTH-1:0] wdata_q;

`ifdef BUS_ARB_LOCK_EN
    logic                  locked;
    logic [IW-1:0]         lock_owner;
    logic                  lock_now;
    logic [IW-1:0]         holder;
    logic [NUM_REQ-1:0]    hold_mask;
`else
    logic                  unused_lock;
    assign unused_lock = ^REQ_LOCK;
`endif

    // The owner still holds REQ in T3, so it is masked to avoid re-running its cycle.
    always_comb begin
        eligible = REQ;
        if (state == T3) eligible[owner] = 1'b0;
`ifdef BUS_ARB_LOCK_EN
        lock_now  = 1'b0;
        holder    = lock_owner;
        hold_mask = '0;
        if (state == T3) begin
            lock_now = REQ_LOCK[owner];
            holder   = owner;
        end else if (state == IDLE) begin
            lock_now = locked && REQ_LOCK[lock_owner];
        end
        hold_mask[holder] = 1'b1;
        if (lock_now) eligible = eligible & hold_mask;
`endif
    end

    // In T3 the LAST register is not yet updated, so rotate from the current owner.
    assign pick_last = (state == T3) ? owner : last;
    assign launch    = pick_any && (state == IDLE || state == T3);
    assign DATA      = data_oe ? wdata_q : 'z;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .eligible     (eligible),
        .last         (pick_last),
        .winner       (pick_onehot),
        .winner_idx   (pick_idx),
        .any_eligible (pick_any)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            last       <= IW'(NUM_REQ - 1);
            owner      <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            data_oe    <= 1'b0;
            GNT        <= '0;
            DONE       <= '0;
            RDATA      <= '0;
            ALE        <= 1'b0;
            CS         <= 1'b0;
            RD         <= 1'b1;
            WR         <= 1'b1;
            ADDRESS    <= '0;
`ifdef BUS_ARB_LOCK_EN
            locked     <= 1'b0;
            lock_owner <= '0;
`endif
        end else begin
            case (state)
                IDLE: ;
                T1: begin
                    ALE     <= 1'b0;
                    RD      <= wr_q;
                    WR      <= !wr_q;
                    data_oe <= wr_q;
                    state   <= T2;
                end
                T2: begin
                    CS      <= 1'b0;
                    RD      <= 1'b1;
                    WR      <= 1'b1;
                    data_oe <= 1'b0;
                    DONE    <= GNT;
                    if (!wr_q) RDATA <= DATA;
                    state   <= T3;
                end
                T3: begin
                    DONE  <= '0;
                    last  <= owner;
                    GNT   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

`ifdef BUS_ARB_LOCK_EN
            if (state == IDLE || state == T3) begin
                locked     <= lock_now;
                lock_owner <= holder;
            end
`endif

            // A new winner overrides the T3->IDLE defaults above.
            if (launch) begin
                owner   <= pick_idx;
                GNT     <= pick_onehot;
                wr_q    <= REQ_WR[pick_idx];
                ADDRESS <= REQ_ADDR[int'(pick_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_q <= REQ_WDATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
                ALE     <= 1'b1;
                CS      <= 1'b1;
                state   <= T1;
            end
        end
    end

endmodule

// File: tb/tb_bus_cycle_arbiter.sv
// Self-checking bench for bus_cycle_arbiter with a behavioural memory device
// and a cycle-level transaction model; lock tests need BUS_ARB_LOCK_EN.
module tb_bus_cycle_arbiter;

    localparam int AW = 19;
    localparam int DW = 8;
    localparam int N  = 2;

    logic            CLK   = 1'b0;
    logic            RESET = 1'b0;
    logic [N-1:0]    REQ       = '0;
    logic [N-1:0]    REQ_WR    = '0;
    logic [N-1:0]    REQ_LOCK  = '0;
    logic [N*AW-1:0] REQ_ADDR  = '0;
    logic [N*DW-1:0] REQ_WDATA = '0;
    logic [N-1:0]    GNT, DONE;
    logic [DW-1:0]   RDATA;
    logic            ALE, CS, RD, WR;
    logic [AW-1:0]   ADDRESS;
    wire  [DW-1:0]   DATA;

    int total = 0;
    int bad   = 0;
    int wr_low_cnt = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];

    bus_cycle_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(N)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .REQ_WR(REQ_WR), .REQ_ADDR(REQ_ADDR),
        .REQ_WDATA(REQ_WDATA), .REQ_LOCK(REQ_LOCK), .GNT(GNT), .DONE(DONE),
        .RDATA(RDATA), .ALE(ALE), .CS(CS), .RD(RD), .WR(WR), .ADDRESS(ADDRESS),
        .DATA(DATA)
    );

    always #5 CLK = ~CLK;

    // Memory/IO device: drives data while selected and read-strobed, stores on write strobe.
    assign DATA = (CS && !RD) ? mem[ADDRESS] : 'z;
    always @(posedge CLK) if (CS && !WR) mem[ADDRESS] = DATA;
    always @(negedge CLK) if (WR === 1'b0) wr_low_cnt++;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Transaction model: position in the bus cycle (0 idle, 1..3 = T1..T3) and the rules of arbitration.
    int            m_pos = 0;
    int            m_owner = 0;
    int            m_last = N - 1;
    bit            m_wr = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_locked = 1'b0;
    int            m_lock_owner = 0;

    function automatic int rr_choose(input logic [N-1:0] elig, input int from);
        for (int step = 1; step <= N; step++) begin
            int cand = (from + step) % N;
            if (elig[cand]) return cand;
        end
        return 0;
    endfunction

    always @(posedge CLK or posedge RESET) begin : model
        logic [N-1:0] elig;
        bit may_start;
        if (RESET) begin
            m_pos = 0; m_owner = 0; m_last = N - 1; m_rdata = '0;
            m_locked = 1'b0; m_lock_owner = 0;
        end else begin
            elig = REQ;
            may_start = 1'b0;
            case (m_pos)
                0: begin
                    may_start = 1'b1;
`ifdef BUS_ARB_LOCK_EN
                    if (m_locked && !REQ_LOCK[m_lock_owner]) m_locked = 1'b0;
                    if (m_locked) elig = elig & (N'(1) << m_lock_owner);
`endif
                end
                1: m_pos = 2;
                2: begin
                    m_pos = 3;
                    if (m_wr) exp_mem[m_addr] = m_wdata;
                    else      m_rdata = exp_mem[m_addr];
                end
                default: begin
                    elig[m_owner] = 1'b0;
                    m_last = m_owner;
                    may_start = 1'b1;
                    m_pos = 0;
`ifdef BUS_ARB_LOCK_EN
                    m_locked = REQ_LOCK[m_owner];
                    m_lock_owner = m_owner;
                    if (m_locked) elig = '0;
`endif
                end
            endcase
            if (may_start && elig != '0) begin
                m_owner = rr_choose(elig, m_last);
                m_pos   = 1;
                m_wr    = REQ_WR[m_owner];
                m_addr  = REQ_ADDR[m_owner*AW +: AW];
                m_wdata = REQ_WDATA[m_owner*DW +: DW];
            end
        end
    end

    always @(negedge CLK) begin
        check_output("gnt",   GNT,  (m_pos != 0) ? (32'd1 << m_owner) : 32'd0);
        check_output("done",  DONE, (m_pos == 3) ? (32'd1 << m_owner) : 32'd0);
        check_output("ale",   ALE,  32'(m_pos == 1));
        check_output("cs",    CS,   32'(m_pos == 1 || m_pos == 2));
        check_output("rd",    RD,   32'(!(m_pos == 2 && !m_wr)));
        check_output("wr",    WR,   32'(!(m_pos == 2 && m_wr)));
        check_output("rdata", RDATA, 32'(m_rdata));
        if (m_pos != 0) check_output("address", ADDRESS, 32'(m_addr));
        if (m_pos == 2 && m_wr) check_output("data_out", DATA, 32'(m_wdata));
    end

    task automatic apply_reset();
        @(posedge CLK); #1;
        RESET = 1'b1;
        REQ = '0;
        REQ_LOCK = '0;
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b0;
    endtask

    task automatic apply_stimulus(input int i, input bit wr, input logic [AW-1:0] a,
                                  input logic [DW-1:0] d, output int cycles);
        bit got = 1'b0;
        cycles = 0;
        @(posedge CLK); #1;
        REQ_WR[i] = wr;
        REQ_ADDR[i*AW +: AW] = a;
        REQ_WDATA[i*DW +: DW] = d;
        REQ[i] = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge CLK);
            cycles++;
            if (DONE[i]) got = 1'b1;
        end
        REQ[i] = 1'b0;
        check_output($sformatf("done_seen_req%0d", i), 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int seen;
        int since;
        int owners[$];
        int gaps[$];
        bit got;

        for (int a = 0; a < (1 << AW); a++) begin
            mem[a] = '0;
            exp_mem[a] = '0;
        end
        mem[19'h00010] = 8'hA5; exp_mem[19'h00010] = 8'hA5;
        mem[19'h00123] = 8'h11; exp_mem[19'h00123] = 8'h11;
        mem[19'h00200] = 8'h5A; exp_mem[19'h00200] = 8'h5A;
        mem[19'h00300] = 8'hC3; exp_mem[19'h00300] = 8'hC3;

        RESET = 1'b1;
        @(negedge CLK);
        check_output("reset_strobes", {28'd0, ALE, CS, RD, WR}, 32'h3);
        check_output("reset_address", ADDRESS, 32'd0);
        check_output("reset_gnt_done", {GNT, DONE}, 32'd0);
        @(posedge CLK); #1 RESET = 1'b0;

        // Idle bus with no requests.
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            check_output("idle_bus", {26'd0, GNT, ALE, CS, RD, WR}, 32'h3);
        end

        // Single read by requester 0.
        apply_stimulus(0, 1'b0, 19'h00010, 8'h00, cyc);
        check_output("read_latency", cyc, 32'd4);
        check_output("read_rdata", RDATA, 32'hA5);

        // Write then read back at the top address.
        wr_low_cnt = 0;
        apply_stimulus(1, 1'b1, 19'h7FFFF, 8'h3C, cyc);
        check_output("write_latency", cyc, 32'd4);
        check_output("write_strobe_cycles", wr_low_cnt, 32'd1);
        check_output("write_mem", mem[19'h7FFFF], 32'h3C);
        check_output("write_keeps_rdata", RDATA, 32'hA5);
        apply_stimulus(0, 1'b0, 19'h7FFFF, 8'h00, cyc);
        check_output("readback_rdata", RDATA, 32'h3C);

        // Both requesters held continuously: alternate 0,1,... at 3 cycles each.
        apply_reset();
        REQ_WR = '0;
        REQ_ADDR[0*AW +: AW] = 19'h00200;
        REQ_ADDR[1*AW +: AW] = 19'h00300;
        REQ = 2'b11;
        seen = 0; since = 0;
        for (int k = 0; k < 40 && seen < 6; k++) begin
            @(negedge CLK);
            since++;
            if (DONE != '0) begin
                owners.push_back(DONE == 2'b01 ? 0 : (DONE == 2'b10 ? 1 : 99));
                gaps.push_back(since);
                since = 0;
                seen++;
                if (seen == 6) REQ = '0;
            end
        end
        check_output("rr_transfer_count", seen, 32'd6);
        for (int k = 0; k < owners.size(); k++) begin
            check_output($sformatf("rr_owner_%0d", k), owners[k], k % 2);
            check_output($sformatf("rr_gap_%0d", k), gaps[k], (k == 0) ? 32'd4 : 32'd3);
        end
        repeat (3) @(negedge CLK);

        // Asynchronous reset in T2 of a write: outputs at reset values at once, memory untouched.
        apply_reset();
        REQ_WR[0] = 1'b1;
        REQ_ADDR[0*AW +: AW] = 19'h00123;
        REQ_WDATA[0*DW +: DW] = 8'h77;
        REQ[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge CLK);
            if (WR === 1'b0) got = 1'b1;
        end
        check_output("abort_reached_t2", 32'(got), 32'd1);
        #2 RESET = 1'b1;
        #1;
        check_output("abort_strobes", {28'd0, ALE, CS, RD, WR}, 32'h3);
        check_output("abort_gnt_done", {GNT, DONE}, 32'd0);
        check_output("abort_address", ADDRESS, 32'd0);
        REQ = '0;
        @(posedge CLK); #1 RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check_output("abort_no_done", DONE, 32'd0);
        end
        check_output("abort_mem_unchanged", mem[19'h00123], 32'h11);

`ifdef BUS_ARB_LOCK_EN
        // Requester 1 locks the bus for three transfers while requester 0 waits.
        apply_reset();
        owners.delete();
        REQ_WR = '0;
        REQ_ADDR[1*AW +: AW] = 19'h00010;
        REQ_ADDR[0*AW +: AW] = 19'h00200;
        REQ_LOCK[1] = 1'b1;
        REQ[1] = 1'b1;
        seen = 0;
        for (int k = 0; k < 60 && owners.size() < 4; k++) begin
            @(negedge CLK);
            if (GNT[1] && !REQ[0]) REQ[0] = 1'b1;
            if (DONE[1]) begin
                owners.push_back(1);
                seen++;
                if (seen == 3) begin
                    REQ[1] = 1'b0;
                    REQ_LOCK[1] = 1'b0;
                end
            end
            if (DONE[0]) begin
                owners.push_back(0);
                REQ[0] = 1'b0;
            end
        end
        check_output("lock_transfer_count", owners.size(), 32'd4);
        for (int k = 0; k < owners.size(); k++)
            check_output($sformatf("lock_owner_%0d", k), owners[k], (k < 3) ? 32'd1 : 32'd0);
        repeat (3) @(negedge CLK);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
